mt_motion_ctrl: RTL and testbench

- Tape motion sequencer for the MT (TM03-style) formatter.
- Accepts function/GO commands and sequences tape motion through accelerate, run and decelerate phases.
- Maintains the two's-complement frame counter (MTFC).
- Generates the mtPRESET, mtACCL and mtFCS status inputs consumed by the tape control register.
- Sits between the MT register decode and the drive/formatter data path.

---
 rtl/mt_motion_pkg.sv | 36 +++
 rtl/mt_motion_timer.sv | 34 +++
 rtl/mt_motion_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mt_motion_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_motion_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mt_motion_pkg                                                |
// | Description : Shared state encoding and function codes for the MT tape     |
// |               motion sequencer.                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mt_motion_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCEL = 3'd1,
        ST_RUN   = 3'd2,
        ST_DECEL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] c_FUN_NOP    = 5'o00;
    localparam logic [4:0] c_FUN_PRESET = 5'o10;
    localparam logic [4:0] c_FUN_SPCFWD = 5'o14;
    localparam logic [4:0] c_FUN_SPCREV = 5'o15;
    localparam logic [4:0] c_FUN_WRITE  = 5'o30;
    localparam logic [4:0] c_FUN_READ   = 5'o34;

    function automatic logic isMotion(input logic [4:0] fun);
        return (fun == c_FUN_SPCFWD) || (fun == c_FUN_SPCREV) ||
               (fun == c_FUN_WRITE)  || (fun == c_FUN_READ);
    endfunction

    // Unrecognised codes behave as NOP.
    function automatic logic [4:0] normFun(input logic [4:0] fun);
        return (isMotion(fun) || (fun == c_FUN_PRESET)) ? fun : c_FUN_NOP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mt_motion_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mt_motion_timer                                              |
// | Description : Loadable down-counter; o_done is high while the count is 0.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mt_motion_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mt_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mt_motion_ctrl                                               |
// | Description : MT tape motion sequencer (accel/run/decel) with frame        |
// |               counter. Optional frame-gap watchdog: MTMOT_TIMEOUT_EN.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mt_motion_ctrl
    import mt_motion_pkg::*;
#(
    parameter int ACCL_CYCLES = 1000,
    parameter int DECL_CYCLES = 500
`ifdef MTMOT_TIMEOUT_EN
    ,
    parameter int TMO_CYCLES  = 65535
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtINIT,
    input  logic [35:0] mtDATAI,
    input  logic        mtWRFC,
    input  logic        mtGO,
    input  logic [4:0]  mtFUN,
    input  logic        mtFRAME,
    input  logic        mtEOR,
    output logic        mtPRESET,
    output logic        mtACCL,
    output logic        mtFCS,
    output logic [15:0] mtFC,
    output logic        mtBUSY,
    output logic        mtDONE,
    output logic        mtRMR,
    output logic        mtTMO
);

    localparam int c_MOT_MAX = (ACCL_CYCLES > DECL_CYCLES) ? ACCL_CYCLES : DECL_CYCLES;
    localparam int c_MOT_W   = $clog2(c_MOT_MAX + 1);
    localparam logic [c_MOT_W-1:0] c_ACCL_LOAD = c_MOT_W'(ACCL_CYCLES - 1);
    localparam logic [c_MOT_W-1:0] c_DECL_LOAD = c_MOT_W'(DECL_CYCLES - 1);

    state_t      r_state, w_stateNext;
    logic [4:0]  r_fun, w_funNext, w_funNorm;
    logic [15:0] r_fc, w_fcNext, w_fcInc;
    logic        r_preset, w_presetNext;
    logic        r_accl, w_acclNext;
    logic        r_fcs, w_fcsNext;
    logic        r_busy, w_busyNext;
    logic        r_done, w_doneNext;
    logic        r_rmr, w_rmrNext;
    logic        w_term;
    logic        w_rst;
    logic        w_motLoad, w_motDone;
    logic [c_MOT_W-1:0] w_motLoadVal;
    logic        w_unusedDataHi;

    assign w_rst          = rst | mtINIT;
    assign w_funNorm      = normFun(mtFUN);
    assign w_fcInc        = r_fc + 16'd1;
    assign w_unusedDataHi = ^mtDATAI[35:16];

    // One timer serves both ACCEL and DECEL, which never overlap.
    mt_motion_timer #(.WIDTH(c_MOT_W)) u_motTimer (
        .clk       (clk),
        .rst       (w_rst),
        .i_load    (w_motLoad),
        .i_loadVal (w_motLoadVal),
        .o_done    (w_motDone)
    );

`ifdef MTMOT_TIMEOUT_EN
    localparam int c_GAP_W = $clog2(TMO_CYCLES + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(TMO_CYCLES - 1);

    logic r_tmo, w_tmoNext;
    logic w_gapLoad, w_gapDone;

    mt_motion_timer #(.WIDTH(c_GAP_W)) u_gapTimer (
        .clk       (clk),
        .rst       (w_rst),
        .i_load    (w_gapLoad),
        .i_loadVal (c_GAP_LOAD),
        .o_done    (w_gapDone)
    );

    assign mtTMO = r_tmo;
`else
    assign mtTMO = 1'b0;
`endif

    always_comb begin
        w_stateNext  = r_state;
        w_funNext    = r_fun;
        w_fcNext     = r_fc;
        w_presetNext = 1'b0;
        w_acclNext   = r_accl;
        w_fcsNext    = r_fcs;
        w_busyNext   = r_busy;
        w_doneNext   = 1'b0;
        w_rmrNext    = 1'b0;
        w_term       = 1'b0;
        w_motLoad    = 1'b0;
        w_motLoadVal = '0;
`ifdef MTMOT_TIMEOUT_EN
        w_tmoNext    = r_tmo;
        w_gapLoad    = 1'b0;
`endif

        // Write lands before a same-cycle GO, so the command sees the new count.
        if (r_state == ST_IDLE) begin
            if (mtWRFC) begin
                w_fcNext = mtDATAI[15:0];
            end
            if (mtGO) begin
`ifdef MTMOT_TIMEOUT_EN
                w_tmoNext = 1'b0;
`endif
                if (isMotion(w_funNorm)) begin
                    w_funNext    = w_funNorm;
                    w_busyNext   = 1'b1;
                    w_fcsNext    = 1'b0;
                    w_motLoad    = 1'b1;
                    w_motLoadVal = c_ACCL_LOAD;
                    w_stateNext  = ST_ACCEL;
                end else begin
                    w_presetNext = (w_funNorm == c_FUN_PRESET);
                    w_stateNext  = ST_DONE;
                end
            end
        end else if (mtGO || mtWRFC) begin
            w_rmrNext = 1'b1;
        end

        case (r_state)
            ST_ACCEL: begin
                if (w_motDone) begin
                    w_acclNext  = 1'b1;
                    w_stateNext = ST_RUN;
`ifdef MTMOT_TIMEOUT_EN
                    w_gapLoad   = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                if (mtFRAME) begin
                    w_fcNext = w_fcInc;
                    if ((r_fun != c_FUN_READ) && (w_fcInc == 16'd0)) begin
                        w_term = 1'b1;
                    end
                end
                if ((r_fun == c_FUN_READ) && mtEOR) begin
                    w_term = 1'b1;
                end
`ifdef MTMOT_TIMEOUT_EN
                if (mtFRAME) begin
                    w_gapLoad = 1'b1;
                end else if (w_gapDone && !w_term) begin
                    w_tmoNext = 1'b1;
                    w_term    = 1'b1;
                end
`endif
                if (w_term) begin
                    w_acclNext   = 1'b0;
                    w_motLoad    = 1'b1;
                    w_motLoadVal = c_DECL_LOAD;
                    w_stateNext  = ST_DECEL;
                end
            end
            ST_DECEL: begin
                if (w_motDone) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                w_doneNext  = 1'b1;
                w_busyNext  = 1'b0;
                w_fcsNext   = (r_fc != 16'd0);
                w_stateNext = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state  <= ST_IDLE;
            r_fun    <= c_FUN_NOP;
            r_fc     <= '0;
            r_preset <= 1'b0;
            r_accl   <= 1'b0;
            r_fcs    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rmr    <= 1'b0;
`ifdef MTMOT_TIMEOUT_EN
            r_tmo    <= 1'b0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_fun    <= w_funNext;
            r_fc     <= w_fcNext;
            r_preset <= w_presetNext;
            r_accl   <= w_acclNext;
            r_fcs    <= w_fcsNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
            r_rmr    <= w_rmrNext;
`ifdef MTMOT_TIMEOUT_EN
            r_tmo    <= w_tmoNext;
`endif
        end
    end

    assign mtPRESET = r_preset;
    assign mtACCL   = r_accl;
    assign mtFCS    = r_fcs;
    assign mtFC     = r_fc;
    assign mtBUSY   = r_busy;
    assign mtDONE   = r_done;
    assign mtRMR    = r_rmr;

endmodule
`default_nettype wire

// File: tb/tb_mt_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mt_motion_ctrl                                            |
// | Description : Scoreboard bench for mt_motion_ctrl (ACCL=8, DECL=4).        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mt_motion_ctrl;

    localparam logic [2:0] c_EV_PRESET = 3'b100;
    localparam logic [2:0] c_EV_DONE   = 3'b010;
    localparam logic [2:0] c_EV_RMR    = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] fc;
        logic        fcs;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mtINIT = 1'b0;
    logic [35:0] mtDATAI = '0;
    logic        mtWRFC = 1'b0;
    logic        mtGO = 1'b0;
    logic [4:0]  mtFUN = '0;
    logic        mtFRAME = 1'b0;
    logic        mtEOR = 1'b0;
    logic        mtPRESET, mtACCL, mtFCS, mtBUSY, mtDONE, mtRMR, mtTMO;
    logic [15:0] mtFC;

    exp_t sb[$];
    exp_t e;
    int   nChecks = 0;
    int   nPass   = 0;
    int   n;

    mt_motion_ctrl #(
        .ACCL_CYCLES (8),
        .DECL_CYCLES (4)
`ifdef MTMOT_TIMEOUT_EN
        ,
        .TMO_CYCLES  (16)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mtINIT   (mtINIT),
        .mtDATAI  (mtDATAI),
        .mtWRFC   (mtWRFC),
        .mtGO     (mtGO),
        .mtFUN    (mtFUN),
        .mtFRAME  (mtFRAME),
        .mtEOR    (mtEOR),
        .mtPRESET (mtPRESET),
        .mtACCL   (mtACCL),
        .mtFCS    (mtFCS),
        .mtFC     (mtFC),
        .mtBUSY   (mtBUSY),
        .mtDONE   (mtDONE),
        .mtRMR    (mtRMR),
        .mtTMO    (mtTMO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [4:0] f);
        mtFUN = f;
        mtGO  = 1'b1;
        tick();
        mtGO  = 1'b0;
    endtask

    task automatic wrfc(input logic [15:0] v);
        mtDATAI = {20'h0, v};
        mtWRFC  = 1'b1;
        tick();
        mtWRFC  = 1'b0;
    endtask

    task automatic frame(input logic eor);
        mtFRAME = 1'b1;
        mtEOR   = eor;
        tick();
        mtFRAME = 1'b0;
        mtEOR   = 1'b0;
        tick();
    endtask

    task automatic waitAccl(output int cnt);
        cnt = 0;
        while (!mtACCL && cnt < 200) begin tick(); cnt++; end
    endtask

    task automatic waitDone(output int cnt);
        cnt = 0;
        while (!mtDONE && cnt < 200) begin tick(); cnt++; end
    endtask

    task automatic pushEv(input logic [2:0] k, input logic [15:0] fc, input logic fcs, input logic busy);
        exp_t x;
        x.kind = k; x.fc = fc; x.fcs = fcs; x.busy = busy;
        sb.push_back(x);
    endtask

    // Monitor: every PRESET/DONE/RMR pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && !mtINIT && (mtPRESET || mtDONE || mtRMR)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {29'h0, mtPRESET, mtDONE, mtRMR}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {29'h0, mtPRESET, mtDONE, mtRMR}, {29'h0, e.kind});
                check("event_fc", {16'h0, mtFC}, {16'h0, e.fc});
                check("event_busy", {31'h0, mtBUSY}, {31'h0, e.busy});
                if (e.kind == c_EV_DONE) check("done_fcs", {31'h0, mtFCS}, {31'h0, e.fcs});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", {9'h0, mtPRESET, mtACCL, mtFCS, mtBUSY, mtDONE, mtRMR, mtTMO, mtFC}, 32'h0);

        // Space forward from -3: three frames wrap the counter to zero.
        wrfc(16'hFFFD);
        check("wrfc_idle", {16'h0, mtFC}, 32'h0000FFFD);
        pushEv(c_EV_DONE, 16'h0000, 1'b0, 1'b0);
        go(5'o14);
        check("busy_after_go", {31'h0, mtBUSY}, 32'h1);
        waitAccl(n);
        check("accel_cycles", n, 8);
        repeat (3) frame(1'b0);
        check("accl_drop", {31'h0, mtACCL}, 32'h0);
        check("fc_wrapped", {16'h0, mtFC}, 32'h0);
        waitDone(n);
        check("decel_to_done", n, 4);
        check("fcs_zero", {31'h0, mtFCS}, 32'h0);
        tick();

        // Read: frame during ACCEL ignored; EOR coincident with 5th frame.
        wrfc(16'hFFF0);
        pushEv(c_EV_DONE, 16'hFFF5, 1'b1, 1'b0);
        go(5'o34);
        frame(1'b0);
        check("accel_frame_ignored", {16'h0, mtFC}, 32'h0000FFF0);
        waitAccl(n);
        check("read_accl", {31'h0, mtACCL}, 32'h1);
        repeat (4) frame(1'b0);
        frame(1'b1);
        check("read_fc", {16'h0, mtFC}, 32'h0000FFF5);
        waitDone(n);
        check("read_done", {31'h0, mtDONE}, 32'h1);
        check("read_fcs", {31'h0, mtFCS}, 32'h1);
        tick();

        // Preset: one-cycle pulse, DONE next cycle, never busy.
        pushEv(c_EV_PRESET, 16'hFFF5, 1'b1, 1'b0);
        pushEv(c_EV_DONE, 16'hFFF5, 1'b1, 1'b0);
        go(5'o10);
        check("preset_pulse", {30'h0, mtPRESET, mtBUSY}, 32'h2);
        tick();
        check("preset_done", {30'h0, mtPRESET, mtDONE}, 32'h1);
        tick();

        // Busy refusals: write and GO during RUN each pulse RMR.
        wrfc(16'hFFFE);
        go(5'o30);
        check("fcs_cleared_on_go", {31'h0, mtFCS}, 32'h0);
        waitAccl(n);
        pushEv(c_EV_RMR, 16'hFFFE, 1'b0, 1'b1);
        wrfc(16'h1234);
        tick();
        pushEv(c_EV_RMR, 16'hFFFE, 1'b0, 1'b1);
        go(5'o34);
        tick();
        check("refused_write_fc", {16'h0, mtFC}, 32'h0000FFFE);
        pushEv(c_EV_DONE, 16'h0000, 1'b0, 1'b0);
        frame(1'b0);
        frame(1'b0);
        waitDone(n);
        check("write_done", {31'h0, mtDONE}, 32'h1);
        tick();

        // GO and WRFC together in IDLE: command uses the new count.
        mtDATAI = 36'hFFFF;
        mtWRFC  = 1'b1;
        mtFUN   = 5'o15;
        mtGO    = 1'b1;
        tick();
        mtWRFC  = 1'b0;
        mtGO    = 1'b0;
        pushEv(c_EV_DONE, 16'h0000, 1'b0, 1'b0);
        waitAccl(n);
        frame(1'b0);
        waitDone(n);
        check("go_wrfc_same_cycle", {31'h0, mtDONE}, 32'h1);
        tick();

        // Initialize mid-RUN aborts without DONE.
        wrfc(16'h0005);
        go(5'o14);
        waitAccl(n);
        frame(1'b0);
        check("run_count", {16'h0, mtFC}, 32'h6);
        mtINIT = 1'b1;
        tick();
        mtINIT = 1'b0;
        check("init_abort", {13'h0, mtBUSY, mtACCL, mtFCS, mtFC}, 32'h0);
        repeat (20) tick();

        // Undefined code and NOP both complete immediately.
        pushEv(c_EV_DONE, 16'h0000, 1'b0, 1'b0);
        go(5'o07);
        tick();
        check("undef_as_nop", {30'h0, mtBUSY, mtDONE}, 32'h1);
        pushEv(c_EV_DONE, 16'h0000, 1'b0, 1'b0);
        go(5'o00);
        tick();
        check("nop_done", {30'h0, mtBUSY, mtDONE}, 32'h1);
        tick();

`ifdef MTMOT_TIMEOUT_EN
        // No frames: watchdog fires after 16 RUN cycles.
        wrfc(16'h0005);
        pushEv(c_EV_DONE, 16'h0005, 1'b1, 1'b0);
        go(5'o30);
        waitAccl(n);
        n = 0;
        while (!mtTMO && n < 200) begin tick(); n++; end
        check("tmo_cycles", n, 16);
        waitDone(n);
        check("tmo_done", {30'h0, mtDONE, mtTMO}, 32'h3);
        tick();
        pushEv(c_EV_DONE, 16'h0005, 1'b1, 1'b0);
        go(5'o00);
        check("tmo_cleared", {31'h0, mtTMO}, 32'h0);
        tick();
        tick();
`endif

        repeat (5) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
